// File: rtl/pbus_master_ctrl.sv
// Peripheral-bus master: runs one registered valid/ready transaction per memory-stage
// request, stalls the pipeline meanwhile, and returns read data, bus error or timeout.
module pbus_master_ctrl #(
   parameter int TIMEOUT_CYCLES = 200,
   parameter int CNT_W          = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear_l3,
   input  logic        req_valid_l2,
   input  logic        req_we_l2,
   input  logic [31:0] req_addr_l2,
   input  logic [31:0] req_wdata_l2,
   input  logic [3:0]  req_be_l2,
   output logic        stall,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        pbus_valid,
   output logic        pbus_we,
   output logic [31:0] pbus_addr,
   output logic [31:0] pbus_wdata,
   output logic [3:0]  pbus_be,
   input  logic        pbus_ready,
   input  logic [31:0] pbus_rdata,
   input  logic        pbus_err
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             drop;
   logic             rsp_valid_r;
   logic             accept, hs, timeout;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      hs        = 1'b0;
      timeout   = 1'b0;
      case (state)
         IDLE: begin
            accept = req_valid_l2 && !clear_l3;
            if (accept) state_nxt = REQ;
         end
         REQ: begin
            hs      = pbus_ready;
            timeout = !pbus_ready && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
            if (hs || timeout) state_nxt = RESP;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign stall     = !rst && (accept || state == REQ);
   // A flush landing in the response cycle itself kills the strobe the pipeline would consume.
   assign rsp_valid = rsp_valid_r && !clear_l3;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pbus_valid  <= 1'b0;
         pbus_we     <= 1'b0;
         pbus_addr   <= '0;
         pbus_wdata  <= '0;
         pbus_be     <= '0;
         rsp_valid_r <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         cnt         <= '0;
         drop        <= 1'b0;
      end else begin
         if (accept) begin
            pbus_valid <= 1'b1;
            pbus_we    <= req_we_l2;
            pbus_addr  <= req_addr_l2;
            pbus_wdata <= req_wdata_l2;
            pbus_be    <= req_be_l2;
            cnt        <= '0;
            drop       <= 1'b0;
         end
         if (state == REQ) begin
            if (clear_l3) drop <= 1'b1;
            if (hs || timeout) begin
               pbus_valid  <= 1'b0;
               rsp_valid_r <= !(drop || clear_l3);
               rsp_rdata   <= (hs && !pbus_we) ? pbus_rdata : 32'h0;
               rsp_err     <= hs ? pbus_err : 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
         if (state == RESP) rsp_valid_r <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pbus_master_ctrl.sv
// Directed bench for pbus_master_ctrl with a short timeout.
module tb_pbus_master_ctrl;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst, clear_l3, req_valid_l2, req_we_l2;
   logic [31:0] req_addr_l2, req_wdata_l2;
   logic [3:0]  req_be_l2;
   logic        stall, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic        pbus_valid, pbus_we, pbus_ready, pbus_err;
   logic [31:0] pbus_addr, pbus_wdata, pbus_rdata;
   logic [3:0]  pbus_be;

   int n_cmp = 0;
   int n_err = 0;

   pbus_master_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .clear_l3(clear_l3),
      .req_valid_l2(req_valid_l2), .req_we_l2(req_we_l2), .req_addr_l2(req_addr_l2),
      .req_wdata_l2(req_wdata_l2), .req_be_l2(req_be_l2),
      .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .pbus_valid(pbus_valid), .pbus_we(pbus_we), .pbus_addr(pbus_addr),
      .pbus_wdata(pbus_wdata), .pbus_be(pbus_be),
      .pbus_ready(pbus_ready), .pbus_rdata(pbus_rdata), .pbus_err(pbus_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request; ready arrives k cycles after valid rises (k>=TO never), clear_l3
   // pulsed in REQ cycle clr_cyc (-1 none) or in the response cycle when clr_resp.
   task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int k, input logic [31:0] rdata,
                       input logic err, input int clr_cyc, input logic clr_resp,
                       input logic exp_vld, input logic [31:0] exp_rdata, input logic exp_err);
      int n;
      req_valid_l2 = 1'b1; req_we_l2 = we; req_addr_l2 = addr;
      req_wdata_l2 = wdata; req_be_l2 = be;
      #1;
      chk("accept_stall", {31'b0, stall}, 32'd1);
      chk("accept_pvalid", {31'b0, pbus_valid}, 32'd0);
      tick();
      req_valid_l2 = 1'b0; req_addr_l2 = 32'h0; req_wdata_l2 = 32'h0; req_be_l2 = 4'h0;
      n = (k < TO) ? k : TO - 1;
      for (int i = 0; i <= n; i++) begin
         pbus_ready = (i == k);
         pbus_rdata = (i == k) ? rdata : 32'hA5A5_A5A5;
         pbus_err   = (i == k) ? err : 1'b1;
         clear_l3   = (i == clr_cyc);
         #1;
         chk("req_pvalid", {31'b0, pbus_valid}, 32'd1);
         chk("req_we", {31'b0, pbus_we}, {31'b0, we});
         chk("req_addr", pbus_addr, addr);
         chk("req_wdata", pbus_wdata, wdata);
         chk("req_be", {28'b0, pbus_be}, {28'b0, be});
         chk("req_stall", {31'b0, stall}, 32'd1);
         chk("req_rvalid", {31'b0, rsp_valid}, 32'd0);
         tick();
      end
      pbus_ready = 1'b0; pbus_err = 1'b0; pbus_rdata = 32'h0;
      clear_l3 = clr_resp;
      #1;
      chk("resp_pvalid", {31'b0, pbus_valid}, 32'd0);
      chk("resp_rvalid", {31'b0, rsp_valid}, {31'b0, exp_vld});
      chk("resp_rdata", rsp_rdata, exp_rdata);
      chk("resp_err", {31'b0, rsp_err}, {31'b0, exp_err});
      chk("resp_stall", {31'b0, stall}, 32'd0);
      tick();
      clear_l3 = 1'b0;
      #1;
      chk("idle_rvalid", {31'b0, rsp_valid}, 32'd0);
      chk("idle_pvalid", {31'b0, pbus_valid}, 32'd0);
      chk("idle_stall", {31'b0, stall}, 32'd0);
      tick();
   endtask

   initial begin
      rst = 1'b1; clear_l3 = 1'b0; req_valid_l2 = 1'b1; req_we_l2 = 1'b1;
      req_addr_l2 = 32'h0; req_wdata_l2 = 32'h0; req_be_l2 = 4'h0;
      pbus_ready = 1'b0; pbus_rdata = 32'h0; pbus_err = 1'b0;
      #1;
      chk("rst_stall", {31'b0, stall}, 32'd0);
      repeat (2) tick();
      chk("rst_pvalid", {31'b0, pbus_valid}, 32'd0);
      chk("rst_rvalid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_addr", pbus_addr, 32'h0);
      chk("rst_rdata", rsp_rdata, 32'h0);
      req_valid_l2 = 1'b0; req_we_l2 = 1'b0;
      @(negedge clk); rst = 1'b0;
      tick();

      // load, ready with valid
      xact(1'b0, 32'h0001_0000, 32'h0, 4'hF, 0, 32'hDEAD_BEEF, 1'b0, -1, 1'b0,
           1'b1, 32'hDEAD_BEEF, 1'b0);
      // store, 3 wait cycles
      xact(1'b1, 32'h0001_0004, 32'h1234_5678, 4'hF, 3, 32'hCAFE_F00D, 1'b0, -1, 1'b0,
           1'b1, 32'h0, 1'b0);
      // timeout
      xact(1'b0, 32'h0001_0008, 32'h0, 4'h3, TO + 5, 32'h0, 1'b0, -1, 1'b0,
           1'b1, 32'h0, 1'b1);
      // ready in last valid cycle beats timeout
      xact(1'b0, 32'h0001_000C, 32'h0, 4'hC, TO - 1, 32'h0000_0055, 1'b0, -1, 1'b0,
           1'b1, 32'h0000_0055, 1'b0);
      // bus error keeps read data
      xact(1'b0, 32'h0001_0010, 32'h0, 4'hF, 1, 32'hFFFF_FFFF, 1'b1, -1, 1'b0,
           1'b1, 32'hFFFF_FFFF, 1'b1);
      // flush in 2nd REQ cycle, ready in 3rd
      xact(1'b1, 32'h0001_0014, 32'h0BAD_CAFE, 4'h1, 2, 32'h0, 1'b0, 1, 1'b0,
           1'b0, 32'h0, 1'b0);
      // flush in response cycle
      xact(1'b0, 32'h0001_0018, 32'h0, 4'hF, 0, 32'h1357_9BDF, 1'b0, -1, 1'b1,
           1'b0, 32'h1357_9BDF, 1'b0);

      // flush with request in IDLE
      req_valid_l2 = 1'b1; clear_l3 = 1'b1; req_addr_l2 = 32'h0001_001C;
      #1;
      chk("idleflush_stall", {31'b0, stall}, 32'd0);
      tick();
      req_valid_l2 = 1'b0; clear_l3 = 1'b0;
      #1;
      chk("idleflush_pvalid", {31'b0, pbus_valid}, 32'd0);
      chk("idleflush_stall2", {31'b0, stall}, 32'd0);
      tick();

      // async reset mid-REQ
      req_valid_l2 = 1'b1; req_we_l2 = 1'b1; req_addr_l2 = 32'h0001_0020;
      req_wdata_l2 = 32'h7777_8888; req_be_l2 = 4'hF;
      tick();
      req_valid_l2 = 1'b0;
      #1;
      chk("arst_pre_pvalid", {31'b0, pbus_valid}, 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("arst_pvalid", {31'b0, pbus_valid}, 32'd0);
      chk("arst_addr", pbus_addr, 32'h0);
      chk("arst_wdata", pbus_wdata, 32'h0);
      chk("arst_we", {31'b0, pbus_we}, 32'd0);
      chk("arst_stall", {31'b0, stall}, 32'd0);
      chk("arst_rvalid", {31'b0, rsp_valid}, 32'd0);
      @(negedge clk); rst = 1'b0;
      tick();
      chk("arst_idle_pvalid", {31'b0, pbus_valid}, 32'd0);
      chk("arst_idle_rvalid", {31'b0, rsp_valid}, 32'd0);
      xact(1'b0, 32'h0001_0024, 32'h0, 4'hF, 0, 32'h2468_ACE0, 1'b0, -1, 1'b0,
           1'b1, 32'h2468_ACE0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
